// File: rtl/tape_ram_writer.sv
// Tape loader to RAM write bridge: captures loader strobes into a FIFO and issues them
// into CPU-idle RAM cycles. Optional running checksum enabled by TAPE_WR_CHECKSUM_EN.
module tape_ram_writer #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned MAX_STALL  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] tape_addr,
    input  logic        tape_wr,
    input  logic [7:0]  tape_dout,
    input  logic        tape_complete,
    input  logic        cpu_mreq,
    output logic [15:0] ram_addr,
    output logic [7:0]  ram_din,
    output logic        ram_we,
    output logic        cpu_wait,
    output logic        busy,
    output logic        load_done,
    output logic        overflow,
    output logic [7:0]  checksum
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned SW = (MAX_STALL > 0) ? $clog2(MAX_STALL + 1) : 1;
    localparam int unsigned EW = 24;

    typedef enum logic [1:0] {IDLE, ISSUE, STALL, DONE} state_t;

    state_t          state_q, state_d;
    logic [EW-1:0]   mem_q [FIFO_DEPTH];
    logic [EW-1:0]   mem_d [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [SW-1:0]   stall_cnt_q, stall_cnt_d;
    logic            pending_q, pending_d;
    logic            prev_wr_q, prev_wr_d;
    logic [15:0]     last_addr_q, last_addr_d;
    logic            prev_complete_q, prev_complete_d;
    logic [15:0]     ram_addr_q, ram_addr_d;
    logic [7:0]      ram_din_q, ram_din_d;
    logic            ram_we_q, ram_we_d;
    logic            cpu_wait_q, cpu_wait_d;
    logic            busy_q, busy_d;
    logic            load_done_q, load_done_d;
    logic            overflow_q, overflow_d;
    logic [7:0]      checksum_q, checksum_d;

    logic            wr_event, comp_rise, comp_fall, fifo_empty, fifo_full;
    logic            push, pop, drop;
    logic [EW-1:0]   head;

    // Capture, FIFO bookkeeping, issue FSM and status outputs.
    always_comb begin
        state_d         = state_q;
        mem_d           = mem_q;
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        count_d         = count_q;
        stall_cnt_d     = stall_cnt_q;
        pending_d       = pending_q;
        prev_wr_d       = tape_wr;
        last_addr_d     = last_addr_q;
        prev_complete_d = tape_complete;
        ram_addr_d      = ram_addr_q;
        ram_din_d       = ram_din_q;
        checksum_d      = checksum_q;

        wr_event   = tape_wr && (!prev_wr_q || (tape_addr != last_addr_q));
        comp_rise  = tape_complete && !prev_complete_q;
        comp_fall  = !tape_complete && prev_complete_q;
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == CW'(FIFO_DEPTH));
        head       = mem_q[rd_ptr_q];

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    if (!cpu_mreq) begin
                        state_d = ISSUE;
                    end else if (stall_cnt_q >= SW'(MAX_STALL - 1)) begin
                        state_d = STALL;
                    end
                end else if (pending_q) begin
                    state_d = DONE;
                end
            end
            ISSUE:   state_d = IDLE;
            STALL:   state_d = ISSUE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // The head is popped on the edge that enters ISSUE, so it lands on the RAM bus then.
        pop  = (state_d == ISSUE);
        push = wr_event && (!fifo_full || pop);
        drop = wr_event && fifo_full && !pop;

        if (wr_event) begin
            last_addr_d = tape_addr;
        end
        if (push) begin
            mem_d[wr_ptr_q] = {tape_addr, tape_dout};
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            ram_addr_d = head[23:8];
            ram_din_d  = head[7:0];
            rd_ptr_d   = rd_ptr_q + AW'(1);
        end
        count_d = count_q + CW'(push) - CW'(pop);

        if (!cpu_mreq || fifo_empty) begin
            stall_cnt_d = '0;
        end else if (stall_cnt_q != SW'(MAX_STALL)) begin
            stall_cnt_d = stall_cnt_q + SW'(1);
        end

        if (comp_fall) begin
            pending_d = 1'b0;
        end else if (comp_rise) begin
            pending_d = 1'b1;
        end else if (state_q == DONE) begin
            pending_d = 1'b0;
        end

        ram_we_d    = pop;
        cpu_wait_d  = (state_d == STALL) || (state_q == STALL);
        busy_d      = (count_d != '0) || (state_d == ISSUE) || (state_d == STALL);
        load_done_d = (state_d == DONE);
        overflow_d  = (overflow_q && !comp_fall) || drop;

`ifdef TAPE_WR_CHECKSUM_EN
        if (comp_fall) begin
            checksum_d = 8'h00;
        end else if (ram_we_q) begin
            checksum_d = checksum_q + ram_din_q;
        end
`else
        checksum_d = 8'h00;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            stall_cnt_q     <= '0;
            pending_q       <= 1'b0;
            prev_wr_q       <= 1'b0;
            last_addr_q     <= '0;
            prev_complete_q <= 1'b0;
            ram_addr_q      <= '0;
            ram_din_q       <= '0;
            ram_we_q        <= 1'b0;
            cpu_wait_q      <= 1'b0;
            busy_q          <= 1'b0;
            load_done_q     <= 1'b0;
            overflow_q      <= 1'b0;
            checksum_q      <= '0;
        end else begin
            state_q         <= state_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            stall_cnt_q     <= stall_cnt_d;
            pending_q       <= pending_d;
            prev_wr_q       <= prev_wr_d;
            last_addr_q     <= last_addr_d;
            prev_complete_q <= prev_complete_d;
            ram_addr_q      <= ram_addr_d;
            ram_din_q       <= ram_din_d;
            ram_we_q        <= ram_we_d;
            cpu_wait_q      <= cpu_wait_d;
            busy_q          <= busy_d;
            load_done_q     <= load_done_d;
            overflow_q      <= overflow_d;
            checksum_q      <= checksum_d;
        end
    end

    // Storage carries no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign ram_addr  = ram_addr_q;
    assign ram_din   = ram_din_q;
    assign ram_we    = ram_we_q;
    assign cpu_wait  = cpu_wait_q;
    assign busy      = busy_q;
    assign load_done = load_done_q;
    assign overflow  = overflow_q;
    assign checksum  = checksum_q;

endmodule

// File: tb/tb_tape_ram_writer.sv
// Directed bench for tape_ram_writer; dut uses defaults, dut_ovf uses MAX_STALL=255.
module tb_tape_ram_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] tape_addr;
    logic        tape_wr;
    logic [7:0]  tape_dout;
    logic        tape_complete;
    logic        cpu_mreq;

    logic [15:0] ram_addr, o_ram_addr;
    logic [7:0]  ram_din, o_ram_din;
    logic        ram_we, o_ram_we;
    logic        cpu_wait, o_cpu_wait;
    logic        busy, o_busy;
    logic        load_done, o_load_done;
    logic        overflow, o_overflow;
    logic [7:0]  checksum, o_checksum;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    tape_ram_writer #(.FIFO_DEPTH(8), .MAX_STALL(4)) dut (
        .clk(clk), .reset(reset), .tape_addr(tape_addr), .tape_wr(tape_wr),
        .tape_dout(tape_dout), .tape_complete(tape_complete), .cpu_mreq(cpu_mreq),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .cpu_wait(cpu_wait),
        .busy(busy), .load_done(load_done), .overflow(overflow), .checksum(checksum)
    );

    tape_ram_writer #(.FIFO_DEPTH(8), .MAX_STALL(255)) dut_ovf (
        .clk(clk), .reset(reset), .tape_addr(tape_addr), .tape_wr(tape_wr),
        .tape_dout(tape_dout), .tape_complete(tape_complete), .cpu_mreq(cpu_mreq),
        .ram_addr(o_ram_addr), .ram_din(o_ram_din), .ram_we(o_ram_we), .cpu_wait(o_cpu_wait),
        .busy(o_busy), .load_done(o_load_done), .overflow(o_overflow), .checksum(o_checksum)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1; tape_wr = 1'b0; tape_addr = '0; tape_dout = '0;
        tape_complete = 1'b0; cpu_mreq = 1'b0;
        tick; tick;
        reset = 1'b0;
    endtask

    task automatic test_reset;
        do_reset;
        n_cmp++;
        if ({ram_addr, ram_din, ram_we, cpu_wait, busy, load_done, overflow, checksum} !== 36'h0) begin
            n_bad++;
            $display("FAIL reset_dut: got %h want 0",
                     {ram_addr, ram_din, ram_we, cpu_wait, busy, load_done, overflow, checksum});
        end
        n_cmp++;
        if ({o_ram_addr, o_ram_din, o_ram_we, o_cpu_wait, o_busy, o_load_done, o_overflow, o_checksum} !== 36'h0) begin
            n_bad++;
            $display("FAIL reset_ovf: got %h want 0",
                     {o_ram_addr, o_ram_din, o_ram_we, o_cpu_wait, o_busy, o_load_done, o_overflow, o_checksum});
        end
    endtask

    task automatic test_single_write;
        do_reset;
        tape_wr = 1'b1; tape_addr = 16'h694D; tape_dout = 8'hA5;
        tick;
        tape_wr = 1'b0;
        n_cmp++;
        if ({ram_we, busy} !== 2'b01) begin
            n_bad++; $display("FAIL single_c1: we,busy got %b want 01", {ram_we, busy});
        end
        tick;
        n_cmp++;
        if ({ram_we, ram_addr, ram_din} !== {1'b1, 16'h694D, 8'hA5}) begin
            n_bad++; $display("FAIL single_c2: we,addr,din got %h want 1694DA5", {ram_we, ram_addr, ram_din});
        end
        tick;
        n_cmp++;
        if ({ram_we, busy} !== 2'b00) begin
            n_bad++; $display("FAIL single_c3: we,busy got %b want 00", {ram_we, busy});
        end
        n_cmp++;
        if ({ram_addr, ram_din} !== {16'h694D, 8'hA5}) begin
            n_bad++; $display("FAIL single_hold: addr,din got %h want 694DA5", {ram_addr, ram_din});
        end
    endtask

    task automatic test_held_strobe;
        logic [15:0] addrs [5] = '{16'h694D, 16'h694D, 16'h694E, 16'h694E, 16'h694F};
        logic [7:0]  dats  [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        logic [23:0] want  [3] = '{24'h694D11, 24'h694E33, 24'h694F55};
        logic [23:0] got [8];
        int nw = 0;
        do_reset;
        for (int c = 0; c < 20; c++) begin
            tape_wr = (c < 5);
            if (c < 5) begin
                tape_addr = addrs[c]; tape_dout = dats[c];
            end
            tick;
            if (ram_we === 1'b1 && nw < 8) begin
                got[nw] = {ram_addr, ram_din}; nw++;
            end
        end
        n_cmp++;
        if (nw !== 3) begin
            n_bad++; $display("FAIL held_count: got %0d writes want 3", nw);
        end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (i >= nw || got[i] !== want[i]) begin
                n_bad++; $display("FAIL held_write%0d: got %h want %h", i, (i < nw) ? got[i] : 24'h0, want[i]);
            end
        end
    endtask

    task automatic test_contention;
        logic [2:0] exp_v;
        do_reset;
        cpu_mreq = 1'b1;
        tape_wr = 1'b1; tape_addr = 16'h1234; tape_dout = 8'h5A;
        tick;
        tape_wr = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            exp_v = {1'(c <= 6), 1'(c == 5 || c == 6), 1'(c == 6)};
            n_cmp++;
            if ({busy, cpu_wait, ram_we} !== exp_v) begin
                n_bad++; $display("FAIL contention_c%0d: busy,wait,we got %b want %b", c, {busy, cpu_wait, ram_we}, exp_v);
            end
            if (c == 6) begin
                n_cmp++;
                if ({ram_addr, ram_din} !== 24'h12345A) begin
                    n_bad++; $display("FAIL contention_data: got %h want 12345A", {ram_addr, ram_din});
                end
            end
            tick;
        end
        cpu_mreq = 1'b0;
    endtask

    task automatic test_overflow;
        logic [23:0] got [12];
        int nw = 0;
        int early = 0;
        do_reset;
        cpu_mreq = 1'b1;
        for (int c = 0; c < 9; c++) begin
            tape_wr = 1'b1; tape_addr = 16'h2000 + 16'(c); tape_dout = 8'h30 + 8'(c);
            tick;
            if (o_ram_we === 1'b1) early++;
        end
        tape_wr = 1'b0;
        tick;
        n_cmp++;
        if ({o_overflow, o_busy, early[0]} !== 3'b110 || early != 0) begin
            n_bad++; $display("FAIL ovf_flag: ovf,busy got %b%b early_writes %0d want 11 and 0", o_overflow, o_busy, early);
        end
        cpu_mreq = 1'b0;
        for (int c = 0; c < 24; c++) begin
            tick;
            if (o_ram_we === 1'b1 && nw < 12) begin
                got[nw] = {o_ram_addr, o_ram_din}; nw++;
            end
        end
        n_cmp++;
        if (nw !== 8) begin
            n_bad++; $display("FAIL ovf_count: got %0d writes want 8", nw);
        end
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (i >= nw || got[i] !== {16'h2000 + 16'(i), 8'h30 + 8'(i)}) begin
                n_bad++; $display("FAIL ovf_write%0d: got %h want %h", i, (i < nw) ? got[i] : 24'h0,
                                  {16'h2000 + 16'(i), 8'h30 + 8'(i)});
            end
        end
        tape_complete = 1'b1;
        tick;
        n_cmp++;
        if (o_overflow !== 1'b1) begin
            n_bad++; $display("FAIL ovf_sticky: got %b want 1", o_overflow);
        end
        tape_complete = 1'b0;
        tick;
        n_cmp++;
        if (o_overflow !== 1'b0) begin
            n_bad++; $display("FAIL ovf_clear: got %b want 0", o_overflow);
        end
    endtask

    task automatic test_completion;
        logic [7:0] dats [3] = '{8'h80, 8'h90, 8'h10};
        int we_cyc [4];
        int nw = 0;
        int nld = 0;
        int ld_cyc = -1;
        logic [7:0] got_d [4];
        do_reset;
        for (int c = 0; c < 16; c++) begin
            tape_wr = (c < 3);
            if (c < 3) begin
                tape_addr = 16'h3000 + 16'(c); tape_dout = dats[c];
            end
            tape_complete = (c >= 3);
            tick;
            if (ram_we === 1'b1 && nw < 4) begin
                we_cyc[nw] = c + 1; got_d[nw] = ram_din; nw++;
            end
            if (load_done === 1'b1) begin
                nld++; ld_cyc = c + 1;
            end
        end
        n_cmp++;
        if (nw !== 3 || we_cyc[0] !== 2) begin
            n_bad++; $display("FAIL done_writes: got %0d writes first at %0d want 3 first at 2", nw, (nw > 0) ? we_cyc[0] : -1);
        end
        n_cmp++;
        if (nld !== 1 || nw < 3 || ld_cyc !== we_cyc[2] + 2) begin
            n_bad++; $display("FAIL done_pulse: got %0d pulses at %0d want 1 at %0d", nld, ld_cyc, (nw >= 3) ? we_cyc[2] + 2 : -1);
        end
        n_cmp++;
        if (nw < 3 || {got_d[0], got_d[1], got_d[2]} !== 24'h809010) begin
            n_bad++; $display("FAIL done_order: got %h want 809010", {got_d[0], got_d[1], got_d[2]});
        end
`ifdef TAPE_WR_CHECKSUM_EN
        n_cmp++;
        if (checksum !== 8'h20) begin
            n_bad++; $display("FAIL checksum_sum: got %h want 20", checksum);
        end
`else
        n_cmp++;
        if (checksum !== 8'h00) begin
            n_bad++; $display("FAIL checksum_off: got %h want 00", checksum);
        end
`endif
        tape_complete = 1'b0;
        tick;
        n_cmp++;
        if ({checksum, load_done} !== 9'h0) begin
            n_bad++; $display("FAIL checksum_clear: cs,ld got %h want 000", {checksum, load_done});
        end
    endtask

    task automatic test_reset_mid;
        int late = 0;
        do_reset;
        cpu_mreq = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tape_wr = 1'b1; tape_addr = 16'h4000 + 16'(c); tape_dout = 8'hC0 + 8'(c);
            tick;
        end
        tape_wr = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++; $display("FAIL midrst_busy: got %b want 1", busy);
        end
        reset = 1'b1;
        tick;
        reset = 1'b0;
        n_cmp++;
        if ({ram_addr, ram_din, ram_we, cpu_wait, busy, load_done, overflow, checksum} !== 36'h0) begin
            n_bad++; $display("FAIL midrst_outputs: got %h want 0",
                              {ram_addr, ram_din, ram_we, cpu_wait, busy, load_done, overflow, checksum});
        end
        cpu_mreq = 1'b0;
        for (int c = 0; c < 12; c++) begin
            tick;
            if (ram_we !== 1'b0 || busy !== 1'b0) late++;
        end
        n_cmp++;
        if (late !== 0) begin
            n_bad++; $display("FAIL midrst_quiet: got %0d active cycles want 0", late);
        end
    endtask

    initial begin
        test_reset;
        test_single_write;
        test_held_strobe;
        test_contention;
        test_overflow;
        test_completion;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tape_ram_writer.md
TAPE_RAM_WRITER -- requirements
Module: tape_ram_writer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, power of two in 2..64: loader write buffer depth in entries.
REQ-002 SHALL have parameter MAX_STALL, default 4: consecutive busy CPU cycles tolerated before the block forces a wait.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 Ports, in this order:
  clk  in  1  system clock.
  reset  in  1  synchronous active-high reset.
  tape_addr  in  16  loader write address.
  tape_wr  in  1  loader write enable, level.
  tape_dout  in  8  loader write data.
  tape_complete  in  1  loader finished, level.
  cpu_mreq  in  1  CPU owns the RAM port this cycle.
  ram_addr  out  16  RAM write address.
  ram_din  out  8  RAM write data.
  ram_we  out  1  RAM write strobe, one cycle per byte.
  cpu_wait  out  1  CPU wait request.
  busy  out  1  FIFO non-empty or write in flight.
  load_done  out  1  one-cycle completion pulse.
  overflow  out  1  sticky lost-byte flag.
  checksum  out  8  running byte sum (see Configuration).

Function
REQ-005 Write event SHALL be tape_wr=1 AND (tape_wr was 0 in the previous cycle OR tape_addr differs from the last captured address); a held tape_wr with an unchanged address SHALL NOT capture again.
REQ-006 Each write event SHALL push {tape_addr, tape_dout} into the FIFO in the same cycle; the FIFO is first-in first-out with pointer wrap at FIFO_DEPTH.
REQ-007 A push while full with no pop in the same cycle SHALL drop the byte and set overflow; a push and pop in the same cycle while full SHALL succeed.
REQ-008 FSM states are IDLE, ISSUE, STALL and DONE.
REQ-009 IDLE -> ISSUE when the FIFO is non-empty and cpu_mreq=0.
REQ-010 IDLE -> STALL when the FIFO is non-empty and cpu_mreq has been 1 for MAX_STALL consecutive cycles. The stall counter SHALL be saturating, and SHALL clear when cpu_mreq=0 or the FIFO is empty.
REQ-011 ISSUE:
  - ram_we=1 for exactly one cycle, with ram_addr/ram_din taken from the FIFO head.
  - Pop the head.
  - Return to IDLE.
  - Latency from push into an empty FIFO to ram_we, with cpu_mreq=0, is 2 cycles.
REQ-012 STALL: cpu_wait=1 for one cycle, then ISSUE unconditionally. cpu_wait SHALL remain 1 through the ISSUE cycle.
REQ-013 A rising edge of tape_complete SHALL set a pending latch. While in IDLE with the latch set and the FIFO empty, the FSM SHALL go to DONE.
REQ-014 DONE: load_done=1 for one cycle, clear the latch, return to IDLE.
REQ-015 A falling edge of tape_complete (new load starting) SHALL clear overflow, the pending latch and checksum.
REQ-016 busy SHALL be 1 whenever the FIFO is non-empty or the state is ISSUE/STALL.
REQ-017 ram_addr/ram_din SHALL hold their last values when ram_we=0.

Reset
REQ-018 Reset SHALL produce:
  - state IDLE, FIFO empty, stall counter 0, pending latch 0.
  - ram_addr=0, ram_din=0, ram_we=0, cpu_wait=0, busy=0, load_done=0, overflow=0, checksum=0.
  - previous-tape_wr and last-captured-address trackers set to 0.
REQ-019 Reset asserted mid-operation SHALL discard buffered bytes with no further ram_we.

Configuration
REQ-020 Macro TAPE_WR_CHECKSUM_EN:
  - Defined: checksum = modulo-256 sum of every byte issued with ram_we=1, updated the cycle after the write.
  - Undefined: checksum is constant 0 and no adder is built.

Verification
REQ-021 Single write: tape_wr rises with addr 0x694D, data 0xA5, cpu_mreq=0 -> ram_we pulse 2 cycles later at 0x694D/0xA5; busy then 0.
REQ-022 Held strobe: tape_wr high 5 cycles with addresses 0x694D, 0x694D, 0x694E, 0x694E, 0x694F -> exactly 3 RAM writes, in order.
REQ-023 Contention: cpu_mreq=1 continuously, one byte queued, MAX_STALL=4 -> after 4 busy cycles, cpu_wait for 2 cycles, with ram_we in the second.
REQ-024 Overflow: 9 distinct writes in consecutive cycles, cpu_mreq=1 held, MAX_STALL=255, FIFO_DEPTH=8 -> overflow=1, 8 bytes written after cpu_mreq drops; a tape_complete 1->0 clears overflow.
REQ-025 Completion: tape_complete rises with 3 bytes still queued -> load_done pulses once, one cycle after the third ram_we plus the DONE entry; with TAPE_WR_CHECKSUM_EN and bytes 0x80, 0x90, 0x10 -> checksum=0x20.
REQ-026 Reset while 4 bytes are queued -> no ram_we after reset; all outputs at reset values the next cycle.
